// File: rtl/renode_pkg.sv
// Shared types for the Renode co-simulation top.
// The interrupt index type is sized for the largest supported line count.
package renode_pkg;

    localparam int MaxInterrupts       = 1024;
    localparam int InterruptIndexWidth = 10;

    typedef logic [InterruptIndexWidth-1:0] interrupt_index_t;

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/renode_priority_encoder.sv
// Lowest-set-bit priority encoder.
// Index is zero when no bit is set.
module renode_priority_encoder #(
    parameter int Width      = 1,
    parameter int IndexWidth = 1
) (
    input  logic [Width-1:0]      i_vector,
    output logic [IndexWidth-1:0] o_index,
    output logic                  o_found
);

    always_comb begin
        o_index = '0;
        o_found = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = Width - 1; i >= 0; i--) begin
            if (i_vector[i]) begin
                o_index = IndexWidth'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/renode_interrupts_bridge.sv
// Interrupt-line monitor: turns each settled level change into one
// (index, level) message on a valid/ready port, lowest index first.
module renode_interrupts_bridge
    import renode_pkg::*;
#(
    parameter int InterruptsCount = 1,
    parameter int IndexWidth      = index_width(InterruptsCount)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [InterruptsCount-1:0] interrupts,
    output logic                       msg_valid,
    input  logic                       msg_ready,
    output logic [IndexWidth-1:0]      msg_index,
    output logic                       msg_level,
    output logic [InterruptsCount-1:0] pending,
    output logic [InterruptsCount-1:0] reported
);

    logic [InterruptsCount-1:0] r_in_q;
    logic [InterruptsCount-1:0] r_reported;
    logic [InterruptsCount-1:0] w_pending;
    logic [InterruptsCount-1:0] w_lowest_onehot;
    logic [IndexWidth-1:0]      w_index;
    logic                       w_found;
    logic                       w_accept;

    assign w_pending = r_in_q ^ r_reported;
    // Isolates the lowest pending line without a variable bit select.
    assign w_lowest_onehot = w_pending & (~w_pending + InterruptsCount'(1));

    renode_priority_encoder #(
        .Width      (InterruptsCount),
        .IndexWidth (IndexWidth)
    ) u_prio (
        .i_vector (w_pending),
        .o_index  (w_index),
        .o_found  (w_found)
    );

    assign msg_valid = w_found;
    assign msg_index = w_found ? w_index : '0;
    assign msg_level = |(w_lowest_onehot & r_in_q);
    assign pending   = w_pending;
    assign reported  = r_reported;
    assign w_accept  = w_found & msg_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_q     <= '0;
            r_reported <= '0;
        end else begin
            r_in_q <= interrupts;
            // Flipping the lowest pending bit stores the level that was offered.
            if (w_accept) begin
                r_reported <= r_reported ^ w_lowest_onehot;
            end
        end
    end

endmodule

// File: tb/tb_renode_interrupts_bridge.sv
// Self-checking bench for renode_interrupts_bridge with 4-line and 8-line instances.
module tb_renode_interrupts_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ints4 = '0;
    logic [7:0] ints8 = '0;
    logic       rdy4 = 1'b0;
    logic       rdy8 = 1'b0;

    logic       v4, lvl4, v8, lvl8;
    logic [1:0] idx4;
    logic [2:0] idx8;
    logic [3:0] pend4, rep4;
    logic [7:0] pend8, rep8;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: last sampled levels and Renode's view.
    logic [7:0] mq4 = '0, mr4 = '0, mq8 = '0, mr8 = '0;
    int  log_idx4[$], log_idx8[$];
    bit  log_lvl4[$], log_lvl8[$];

    always #5 clk = ~clk;

    renode_interrupts_bridge #(.InterruptsCount(4)) dut4 (
        .clk(clk), .rst(rst), .interrupts(ints4), .msg_valid(v4), .msg_ready(rdy4),
        .msg_index(idx4), .msg_level(lvl4), .pending(pend4), .reported(rep4)
    );

    renode_interrupts_bridge #(.InterruptsCount(8)) dut8 (
        .clk(clk), .rst(rst), .interrupts(ints8), .msg_valid(v8), .msg_ready(rdy8),
        .msg_index(idx8), .msg_level(lvl8), .pending(pend8), .reported(rep8)
    );

    function automatic int lowest(input logic [7:0] p);
        for (int i = 0; i < 8; i++) if (p[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: Renode's view only ever absorbs the lowest differing line, once per accepted edge.
    always @(posedge clk or posedge rst) begin
        int p;
        if (rst) begin
            mq4 = '0; mr4 = '0; mq8 = '0; mr8 = '0;
        end else begin
            p = lowest((mq4 ^ mr4) & 8'h0f);
            if (p >= 0 && rdy4) begin
                mr4[p] = mq4[p];
                log_idx4.push_back(p);
                log_lvl4.push_back(mq4[p]);
                $display("accept4 index=%0d level=%0b t=%0t", p, mq4[p], $time);
            end
            p = lowest(mq8 ^ mr8);
            if (p >= 0 && rdy8) begin
                mr8[p] = mq8[p];
                log_idx8.push_back(p);
                log_lvl8.push_back(mq8[p]);
                $display("accept8 index=%0d level=%0b t=%0t", p, mq8[p], $time);
            end
            mq4 = {4'b0, ints4};
            mq8 = ints8;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [7:0] pe4, pe8;
        int l4, l8;
        pe4 = (mq4 ^ mr4) & 8'h0f;
        pe8 = mq8 ^ mr8;
        l4 = lowest(pe4);
        l8 = lowest(pe8);
        check("valid4", 32'(v4), 32'(l4 >= 0));
        check("index4", 32'(idx4), (l4 >= 0) ? 32'(l4) : 32'd0);
        check("level4", 32'(lvl4), (l4 >= 0) ? 32'(mq4[l4]) : 32'd0);
        check("pending4", 32'(pend4), 32'(pe4[3:0]));
        check("reported4", 32'(rep4), 32'(mr4[3:0]));
        check("valid8", 32'(v8), 32'(l8 >= 0));
        check("index8", 32'(idx8), (l8 >= 0) ? 32'(l8) : 32'd0);
        check("level8", 32'(lvl8), (l8 >= 0) ? 32'(mq8[l8]) : 32'd0);
        check("pending8", 32'(pend8), 32'(pe8));
        check("reported8", 32'(rep8), 32'(mr8));
    end

    initial begin
        int n;
        // Reset with lines 0 and 2 high: outputs stay zero.
        ints4 = 4'b0101;
        rdy4  = 1'b1;
        rdy8  = 1'b1;
        repeat (3) step();
        check("rst_valid", 32'(v4), 32'd0);
        check("rst_pending", 32'(pend4), 32'd0);
        check("rst_reported", 32'(rep4), 32'd0);
        rst = 1'b0;
        repeat (4) step();
        check("resync_count", 32'(log_idx4.size()), 32'd2);
        if (log_idx4.size() == 2) begin
            check("resync_idx0", 32'(log_idx4[0]), 32'd0);
            check("resync_lvl0", 32'(log_lvl4[0]), 32'd1);
            check("resync_idx1", 32'(log_idx4[1]), 32'd2);
            check("resync_lvl1", 32'(log_lvl4[1]), 32'd1);
        end
        check("resync_reported", 32'(rep4), 32'h5);
        check("resync_idle", 32'(v4), 32'd0);

        // Raise line 3 under stall; payload must hold until accepted.
        rdy4  = 1'b0;
        ints4 = 4'b1101;
        step();
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", 32'(v4), 32'd1);
            check("stall_index", 32'(idx4), 32'd3);
            check("stall_level", 32'(lvl4), 32'd1);
            step();
        end
        n = log_idx4.size();
        rdy4 = 1'b1;
        step();
        check("stall_accepts", 32'(log_idx4.size()), 32'(n + 1));
        check("stall_reported3", 32'(rep4[3]), 32'd1);
        check("stall_idle", 32'(v4), 32'd0);

        // Two-cycle glitch on line 1 while stalled: absorbed.
        rdy4  = 1'b0;
        n = log_idx4.size();
        ints4 = 4'b1111;
        step();
        check("glitch_valid", 32'(v4), 32'd1);
        step();
        ints4 = 4'b1101;
        step();
        check("glitch_dropped", 32'(v4), 32'd0);
        rdy4 = 1'b1;
        repeat (3) step();
        check("glitch_no_msg", 32'(log_idx4.size()), 32'(n));
        check("glitch_reported", 32'(rep4), 32'hd);

        // Lines 6, 2, 0 rise together: drained in ascending order.
        ints8 = 8'b0100_0101;
        repeat (4) step();
        check("simul_count", 32'(log_idx8.size()), 32'd3);
        if (log_idx8.size() == 3) begin
            check("simul_first", 32'(log_idx8[0]), 32'd0);
            check("simul_second", 32'(log_idx8[1]), 32'd2);
            check("simul_third", 32'(log_idx8[2]), 32'd6);
        end

        // Line 0 drops on the very edge that accepts its rise.
        ints8 = 8'b0100_0100;
        repeat (3) step();
        log_idx8.delete();
        log_lvl8.delete();
        rdy8  = 1'b0;
        ints8 = 8'b0100_0101;
        repeat (2) step();
        rdy8  = 1'b1;
        ints8 = 8'b0100_0100;
        step();
        check("cda_first_count", 32'(log_idx8.size()), 32'd1);
        if (log_idx8.size() >= 1) check("cda_first_level", 32'(log_lvl8[0]), 32'd1);
        check("cda_repending_valid", 32'(v8), 32'd1);
        check("cda_repending_index", 32'(idx8), 32'd0);
        check("cda_repending_level", 32'(lvl8), 32'd0);
        step();
        check("cda_second_count", 32'(log_idx8.size()), 32'd2);
        if (log_idx8.size() >= 2) check("cda_second_level", 32'(log_lvl8[1]), 32'd0);

        // Three lines pending, then reset between edges.
        rdy4  = 1'b0;
        ints4 = 4'b0011;
        step();
        check("pre_async_pending", 32'(pend4), 32'he);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(v4), 32'd0);
        check("async_pending", 32'(pend4), 32'd0);
        check("async_reported", 32'(rep4), 32'd0);
        check("async_reported8", 32'(rep8), 32'd0);
        step();
        rst = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
